// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared audio-path definitions: sample width and the signed
//                sample type exchanged between sound_gen and i2s_tx.
//  Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

    // Width of one PCM sample on the audio path.
    localparam int SAMPLE_W = 16;

    // Two's-complement PCM sample.
    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/i2s_bclk_div.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_bclk_div
//  Description : Bit-clock divider. While i_run is high the counter runs
//                0..BCLK_DIV-1 and o_bclk toggles at terminal count. The
//                one-clk rise_tick / fall_tick pulses are asserted on the
//                clk edge at which o_bclk goes high / low respectively.
//                While i_run is low the counter and o_bclk are held at 0.
//  Ports       : clk, rst       clock, synchronous active-high reset
//                i_run          divider enable (clears when low)
//                o_bclk         bit clock
//                rise_tick      o_bclk goes 0->1 at this edge
//                fall_tick      o_bclk goes 1->0 at this edge
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_bclk_div #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_bclk,
    output logic rise_tick,
    output logic fall_tick
);

    // A divide-by-1 still needs a one-bit counter to keep widths legal.
    localparam int                 c_DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_bclk;
    logic               w_term;

    assign w_term = i_run && (r_div == c_DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_term) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + c_DIV_W'(1);
        end
    end

    assign o_bclk    = r_bclk;
    assign rise_tick = w_term & ~r_bclk;
    assign fall_tick = w_term &  r_bclk;

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx
//  Description : Philips I2S transmitter and audio timing master. Paces the
//                upstream generator with sample_strobe, latches one
//                left/right pair per frame and shifts it out MSB first with
//                the standard one-bit delay after each LRCLK edge.
//                Frame rate = clk / (4 * BCLK_DIV * SLOT_W).
//  Ports       : clk, rst                clock, synchronous active-high reset
//                en                      run request
//                left_sample/right_sample signed samples from sound_gen
//                sample_strobe           one-clk request for the next pair
//                i2s_bclk/lrclk/sdata    I2S bus to the DAC
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_tx
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 4,
    parameter int SLOT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] left_sample,
    input  logic [SAMPLE_W-1:0] right_sample,
    output logic                sample_strobe,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata
);

    localparam int                 c_FRAME_W = 2 * SLOT_W;
    localparam int                 c_CNT_W   = $clog2(c_FRAME_W);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(c_FRAME_W - 1);
    localparam logic [c_CNT_W-1:0] c_SLOT    = c_CNT_W'(SLOT_W);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_next;

    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [c_FRAME_W-1:0] r_shadow;
    logic [c_FRAME_W-1:0] w_frame;
    logic                 r_delay;
    logic                 r_sdata;
    logic                 r_lrclk;
    logic                 r_strobe;
    logic                 r_stop_pending;

    logic                 w_div_run;
    logic                 w_bclk;
    logic                 w_fall_tick;
    logic                 w_start;
    logic                 w_fall;
    logic                 w_enter_first;
    logic                 w_enter_last;
    logic                 w_stop;

    // ------------------------------------------------------------------
    // Bit clock
    // ------------------------------------------------------------------
    assign w_div_run = (r_state == c_RUN);

    i2s_bclk_div #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_div (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_div_run),
        .o_bclk    (w_bclk),
        .rise_tick (),
        .fall_tick (w_fall_tick)
    );

    // ------------------------------------------------------------------
    // Frame word: left slot then right slot, each sample left-justified
    // in its slot with zero padding; bit 0 of the frame is the MSB here.
    // ------------------------------------------------------------------
    always_comb begin
        w_frame = '0;
        w_frame[c_FRAME_W-1 -: SAMPLE_W] = left_sample;
        w_frame[SLOT_W-1    -: SAMPLE_W] = right_sample;
    end

    // Explicit wrap keeps non-power-of-two frame lengths correct.
    assign w_cnt_next = (r_bit_cnt == c_LAST) ? '0 : r_bit_cnt + c_CNT_W'(1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (en)     w_state_next = c_RUN;
            c_RUN:   if (w_stop) w_state_next = c_IDLE;
            default:             w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: control decodes
    // ------------------------------------------------------------------
    always_comb begin
        w_start       = (r_state == c_IDLE) && en;
        w_fall        = (r_state == c_RUN) && w_fall_tick;
        w_enter_first = w_fall && (r_bit_cnt == c_LAST);
        w_enter_last  = w_fall && (w_cnt_next == c_LAST);
        w_stop        = w_enter_first && r_stop_pending;
    end

    // ------------------------------------------------------------------
    // Datapath: bit counter, shadow shifter, delay flop, bus outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt      <= '0;
            r_shadow       <= '0;
            r_delay        <= 1'b0;
            r_sdata        <= 1'b0;
            r_lrclk        <= 1'b0;
            r_strobe       <= 1'b0;
            r_stop_pending <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_start) begin
                // Priming bit: pretend we are in the last (right) bit so
                // the first fall enters bit 0 and latches the first pair.
                r_strobe       <= 1'b1;
                r_bit_cnt      <= c_LAST;
                r_lrclk        <= 1'b1;
                r_sdata        <= 1'b0;
                r_delay        <= 1'b0;
                r_shadow       <= '0;
                r_stop_pending <= 1'b0;
            end else if (w_stop) begin
                r_bit_cnt      <= '0;
                r_lrclk        <= 1'b0;
                r_sdata        <= 1'b0;
                r_delay        <= 1'b0;
                r_stop_pending <= 1'b0;
            end else if (w_fall) begin
                r_bit_cnt <= w_cnt_next;
                r_lrclk   <= (w_cnt_next >= c_SLOT);
                if (w_enter_first) begin
                    // One-bit delay: the previous frame's final bit goes
                    // out in bit 0 while the new pair is captured.
                    r_sdata  <= r_delay;
                    r_shadow <= w_frame;
                end else begin
                    r_sdata  <= r_shadow[c_FRAME_W-1];
                    r_shadow <= {r_shadow[c_FRAME_W-2:0], 1'b0};
                end
                if (w_enter_last) begin
                    // Frame bit 2*SLOT_W-1 has no slot of its own in this
                    // frame; park it for the next frame's bit 0.
                    r_delay        <= r_shadow[c_FRAME_W-2];
                    r_strobe       <= en;
                    r_stop_pending <= ~en;
                end
            end
        end
    end

    assign sample_strobe = r_strobe;
    assign i2s_bclk      = w_bclk;
    assign i2s_lrclk     = r_lrclk;
    assign i2s_sdata     = r_sdata;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tx
//  Description : Self-checking bench for i2s_tx. Directed vectors against
//                a default instance (BCLK_DIV=4, SLOT_W=32) and a compact
//                instance (BCLK_DIV=1, SLOT_W=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        en2 = 1'b0;
    logic [15:0] left_s  = 16'h0000;
    logic [15:0] right_s = 16'h0000;
    logic [15:0] left2   = 16'h0000;
    logic [15:0] right2  = 16'h0000;

    logic strobe1, bclk1, lr1, sd1;
    logic strobe2, bclk2, lr2, sd2;

    always #5 clk = ~clk;

    i2s_tx u_dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .left_sample   (left_s),
        .right_sample  (right_s),
        .sample_strobe (strobe1),
        .i2s_bclk      (bclk1),
        .i2s_lrclk     (lr1),
        .i2s_sdata     (sd1)
    );

    i2s_tx #(
        .BCLK_DIV (1),
        .SLOT_W   (16)
    ) u_dut_s (
        .clk           (clk),
        .rst           (rst),
        .en            (en2),
        .left_sample   (left2),
        .right_sample  (right2),
        .sample_strobe (strobe2),
        .i2s_bclk      (bclk2),
        .i2s_lrclk     (lr2),
        .i2s_sdata     (sd2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe / lrclk-fall timestamps of the default instance.
    int   q_str[$];
    int   q_lrf[$];
    int   n_wide  = 0;
    logic prev_str = 1'b0;
    logic prev_lr  = 1'b0;

    always @(negedge clk) begin
        if (strobe1) q_str.push_back(cyc);
        if (strobe1 && prev_str) n_wide++;
        if (prev_lr && !lr1) q_lrf.push_back(cyc);
        prev_str = strobe1;
        prev_lr  = lr1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the negedge at relative clk t (t=0 is the start edge).
    task automatic wait_until(input int t);
        while (cyc - t0 < t) @(negedge clk);
    endtask

    task automatic start_run(input bit second);
        if (second) en2 = 1'b1;
        else        en  = 1'b1;
        t0 = cyc + 1;
        wait_until(0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] got_l;
        logic [15:0] got_r;
        int          nz;
        int          nbad;
        logic        lr_b0, lr_b31, lr_b32;

        // ---------------- 1: reset and idle ----------------
        repeat (3) @(negedge clk);
        check("rst_outs", {strobe1, bclk1, lr1, sd1, strobe2, bclk2, lr2, sd2}, 0);
        rst = 1'b0;
        en  = 1'b0;
        nz  = 0;
        repeat (100) begin
            @(negedge clk);
            if ({strobe1, bclk1, lr1, sd1, strobe2, bclk2, lr2, sd2} != 0) nz++;
        end
        check("idle_quiet", nz, 0);

        // ---------------- 4: SLOT_W=16, BCLK_DIV=1 ----------------
        left2  = 16'h1234;
        right2 = 16'h0001;
        start_run(1'b1);
        check("s16_strobe", strobe2, 1);
        wait_until(2);
        check("s16_first_fall", {bclk2, lr2}, 2'b00);
        got_l = '0;
        for (int k = 1; k <= 16; k++) begin
            wait_until(3 + 2 * k);
            got_l = {got_l[14:0], sd2};
        end
        check("s16_left", got_l, 16'h1234);
        wait_until(65);
        check("s16_bit31", {lr2, sd2}, 2'b10);
        wait_until(67);
        check("s16_lsb_bit0", {bclk2, lr2, sd2}, 3'b101);
        en2 = 1'b0;

        // ---------------- 2/3: default frame and steady run ----------------
        do_reset();
        q_str.delete();
        q_lrf.delete();
        n_wide  = 0;
        left_s  = 16'hA5F0;
        right_s = 16'h0F0F;
        start_run(1'b0);
        check("start_outs", {strobe1, bclk1, lr1, sd1}, 4'b1010);
        wait_until(3);
        check("pre_rise_bclk", bclk1, 0);
        wait_until(4);
        check("first_rise", bclk1, 1);
        wait_until(8);
        check("first_fall", {bclk1, lr1}, 2'b00);
        got_l = '0;
        got_r = '0;
        nz    = 0;
        nbad  = 0;
        lr_b0 = 1'b1; lr_b31 = 1'b1; lr_b32 = 1'b0;
        for (int k = 0; k < 64; k++) begin
            wait_until(12 + 8 * k);
            if (k >= 1 && k <= 16)       got_l = {got_l[14:0], sd1};
            else if (k >= 33 && k <= 48) got_r = {got_r[14:0], sd1};
            else if (sd1)                nz++;
            if (!bclk1) nbad++;
            if (k == 0)  lr_b0  = lr1;
            if (k == 31) lr_b31 = lr1;
            if (k == 32) lr_b32 = lr1;
        end
        check("left_word", got_l, 16'hA5F0);
        check("right_word", got_r, 16'h0F0F);
        check("pad_bits_zero", nz, 0);
        check("sample_on_rise", nbad, 0);
        check("lr_bit0", lr_b0, 0);
        check("lr_bit31", lr_b31, 0);
        check("lr_bit32", lr_b32, 1);
        wait_until(1560);
        check("strobe_count", q_str.size(), 4);
        check("lrfall_count", q_lrf.size(), 4);
        for (int i = 1; i < 4; i++)
            if (i < q_str.size()) check("strobe_period", q_str[i] - q_str[i-1], 512);
        for (int i = 0; i < 4; i++)
            if (i < q_str.size() && i < q_lrf.size())
                check("strobe_lead", q_lrf[i] - q_str[i], 8);
        check("strobe_width", n_wide, 0);

        // ---------------- 5: stop mid-frame ----------------
        en = 1'b0;
        do_reset();
        q_str.delete();
        start_run(1'b0);
        wait_until(90);
        en = 1'b0;
        wait_until(519);
        check("stop_frame_runs", {bclk1, lr1}, 2'b11);
        wait_until(520);
        check("stop_idle", {strobe1, bclk1, lr1, sd1}, 0);
        nz = 0;
        repeat (60) begin
            @(negedge clk);
            if ({strobe1, bclk1, lr1, sd1} != 0) nz++;
        end
        check("stop_quiet", nz, 0);
        check("stop_no_strobe", q_str.size(), 1);
        start_run(1'b0);
        check("restart_outs", {strobe1, bclk1, lr1, sd1}, 4'b1010);
        wait_until(8);
        check("restart_fall", {bclk1, lr1}, 2'b00);

        // ---------------- 6: reset mid-frame ----------------
        en = 1'b0;
        do_reset();
        start_run(1'b0);
        wait_until(330);
        check("midrst_bit40_lr", lr1, 1);
        rst = 1'b1;
        wait_until(331);
        check("midrst_outs", {strobe1, bclk1, lr1, sd1}, 0);
        rst = 1'b0;
        wait_until(332);
        check("midrst_restart", {strobe1, bclk1, lr1, sd1}, 4'b1010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
